// File: rtl/mem_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_write_arbiter
//  Description : Shares one memory write port between CPU MEM-stage stores
//                and a DMA/boot-loader valid/ready master. The CPU wins by
//                default. DMA access is starvation-bounded and bursts are
//                capped. The module also decodes the target region and
//                generates the byte-lane enables. Write outputs are
//                registered toward the BRAMs.
//                Optional feature macro: ARB_WRITE_COUNT_EN (per-requester
//                write counters; the counter ports read 0 when undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_write_arbiter #(
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        cpu_stall,
    input  logic        dma_valid,
    input  logic [1:0]  dma_size,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  data_we,
    output logic [3:0]  instr_we,
    output logic [3:0]  isr_we,
    output logic        misalign,
    output logic [15:0] cpu_wr_cnt,
    output logic [15:0] dma_wr_cnt
);

    localparam int WAIT_W  = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
    localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [WAIT_W-1:0]  C_WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] C_BURST_LAST = BURST_W'(BURST_MAX - 1);
    localparam logic [BURST_W-1:0] C_BURST_ONE  = BURST_W'(1);

    typedef enum logic [0:0] {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic                cpu_grant;
    logic                dma_grant;

    // Byte-lane enables, big-endian: bit 3 is the byte at offset 00.
    // Returns {misaligned, enables}; a misaligned/invalid access has no lanes.
    function automatic logic [4:0] lane_decode(input logic [1:0] size, input logic [1:0] off);
        logic [4:0] r;
        r = 5'b0_0000;
        case (size)
            2'b00: begin
                case (off)
                    2'b00:   r = 5'b0_1000;
                    2'b01:   r = 5'b0_0100;
                    2'b10:   r = 5'b0_0010;
                    default: r = 5'b0_0001;
                endcase
            end
            2'b01: begin
                if (off[0])      r = 5'b1_0000;
                else if (off[1]) r = 5'b0_0011;
                else             r = 5'b0_1100;
            end
            2'b10: begin
                if (off != 2'b00) r = 5'b1_0000;
                else              r = 5'b0_1111;
            end
            default: r = 5'b1_0000;
        endcase
        return r;
    endfunction

    // Right-justified store data replicated so every enabled lane sees it.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Arbitration and next-state: grants, starvation and burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        cpu_grant   = 1'b0;
        dma_grant   = 1'b0;
        case (state_q)
            S_CPU: begin
                dma_grant = dma_valid & (~cpu_req | (wait_cnt_q == C_WAIT_LAST));
                cpu_grant = cpu_req & ~dma_grant;
                if (dma_grant) begin
                    wait_cnt_d = '0;
                    // The granted beat is the first of the burst.
                    if (!dma_last && (BURST_MAX > 1)) begin
                        state_d     = S_DMA;
                        burst_cnt_d = C_BURST_ONE;
                    end
                end else if (dma_valid && cpu_req) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_DMA: begin
                dma_grant = dma_valid;
                if (!dma_valid || dma_last || (burst_cnt_q == C_BURST_LAST)) begin
                    state_d     = S_CPU;
                    burst_cnt_d = '0;
                    wait_cnt_d  = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    assign dma_ready = (state_q == S_DMA) | dma_grant;
    assign cpu_stall = cpu_req & ~cpu_grant;

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_CPU;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    logic        beat_accept;
    logic [1:0]  beat_size;
    logic [31:0] beat_addr;
    logic [31:0] beat_wdata;
    logic [4:0]  beat_lanes;
    logic        beat_misalign;
    logic [3:0]  beat_we;
    logic [3:0]  nib;
    logic        hit_data;
    logic        hit_instr;
    logic        hit_isr;
    logic        instr_allowed;

    // Winning beat selection, region decode and lane enables.
    always_comb begin
        beat_accept   = cpu_grant | dma_grant;
        beat_size     = dma_grant ? dma_size  : cpu_size;
        beat_addr     = dma_grant ? dma_addr  : cpu_addr;
        beat_wdata    = dma_grant ? dma_wdata : cpu_wdata;
        beat_lanes    = lane_decode(beat_size, beat_addr[1:0]);
        beat_misalign = beat_lanes[4];
        beat_we       = beat_lanes[3:0];
        nib           = beat_addr[31:28];
        hit_data      = (nib[3:2] == 2'b00) & nib[0];
        hit_instr     = (nib[3:2] == 2'b00) & nib[1];
        hit_isr       = (nib == 4'b1100);
        // CPU may only patch instruction memory from privileged code.
        instr_allowed = dma_grant | cpu_pc[30];
    end

    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  data_we_q, data_we_d;
    logic [3:0]  instr_we_q, instr_we_d;
    logic [3:0]  isr_we_q, isr_we_d;
    logic        misalign_q, misalign_d;

    // Next write-port values; enables and misalign pulse only on an accept.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        data_we_d   = 4'b0000;
        instr_we_d  = 4'b0000;
        isr_we_d    = 4'b0000;
        misalign_d  = 1'b0;
        if (beat_accept) begin
            mem_addr_d  = beat_addr;
            mem_wdata_d = replicate(beat_size, beat_wdata);
            data_we_d   = hit_data  ? beat_we : 4'b0000;
            instr_we_d  = (hit_instr && instr_allowed) ? beat_we : 4'b0000;
            isr_we_d    = hit_isr   ? beat_we : 4'b0000;
            misalign_d  = beat_misalign;
        end
    end

    // Registered write port toward the BRAMs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            data_we_q   <= '0;
            instr_we_q  <= '0;
            isr_we_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            data_we_q   <= data_we_d;
            instr_we_q  <= instr_we_d;
            isr_we_q    <= isr_we_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign data_we   = data_we_q;
    assign instr_we  = instr_we_q;
    assign isr_we    = isr_we_q;
    assign misalign  = misalign_q;

`ifdef ARB_WRITE_COUNT_EN
    logic [15:0] cpu_wr_cnt_q, cpu_wr_cnt_d;
    logic [15:0] dma_wr_cnt_q, dma_wr_cnt_d;

    // Count well-formed accepted writes per requester; wraps naturally.
    always_comb begin
        cpu_wr_cnt_d = cpu_wr_cnt_q;
        dma_wr_cnt_d = dma_wr_cnt_q;
        if (cpu_grant && !beat_misalign) cpu_wr_cnt_d = cpu_wr_cnt_q + 16'd1;
        if (dma_grant && !beat_misalign) dma_wr_cnt_d = dma_wr_cnt_q + 16'd1;
    end

    // Write counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_wr_cnt_q <= 16'h0;
            dma_wr_cnt_q <= 16'h0;
        end else begin
            cpu_wr_cnt_q <= cpu_wr_cnt_d;
            dma_wr_cnt_q <= dma_wr_cnt_d;
        end
    end

    assign cpu_wr_cnt = cpu_wr_cnt_q;
    assign dma_wr_cnt = dma_wr_cnt_q;
`else
    assign cpu_wr_cnt = 16'h0;
    assign dma_wr_cnt = 16'h0;
`endif

    // Only cpu_pc[30] carries meaning here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{cpu_pc[31], cpu_pc[29:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_write_arbiter
//  Description : Self-checking bench for mem_write_arbiter (MAX_WAIT=8,
//                BURST_MAX=16). Vector table plus multi-cycle sequences for
//                starvation, burst cap and reset mid-burst.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
    logic        cpu_stall;
    logic        dma_valid;
    logic [1:0]  dma_size;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_last;
    logic        dma_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  data_we, instr_we, isr_we;
    logic        misalign;
    logic [15:0] cpu_wr_cnt, dma_wr_cnt;

    always #5 clk = ~clk;

    mem_write_arbiter #(.MAX_WAIT(8), .BURST_MAX(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_size(dma_size), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_ready(dma_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .data_we(data_we),
        .instr_we(instr_we), .isr_we(isr_we), .misalign(misalign),
        .cpu_wr_cnt(cpu_wr_cnt), .dma_wr_cnt(dma_wr_cnt)
    );

    typedef struct packed {
        logic        cpu_req;
        logic [1:0]  cpu_size;
        logic [31:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic [31:0] cpu_pc;
        logic        dma_valid;
        logic [1:0]  dma_size;
        logic [31:0] dma_addr;
        logic [31:0] dma_wdata;
        logic        dma_last;
        logic        exp_stall;
        logic        exp_ready;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_dwe;
        logic [3:0]  exp_iwe;
        logic [3:0]  exp_swe;
        logic        exp_mis;
        logic        chk_data;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cpu_cnt = 16'h0;
    logic [15:0] exp_dma_cnt = 16'h0;
    int          beat;
    logic        exp_dma;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic chk_regs(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] dwe, input logic [3:0] iwe, input logic [3:0] swe,
                            input logic mis, input logic chk_data);
        if (chk_data) begin
            chk({name, ".mem_addr"}, mem_addr, addr);
            chk({name, ".mem_wdata"}, mem_wdata, wdata);
        end
        chk({name, ".data_we"}, {28'h0, data_we}, {28'h0, dwe});
        chk({name, ".instr_we"}, {28'h0, instr_we}, {28'h0, iwe});
        chk({name, ".isr_we"}, {28'h0, isr_we}, {28'h0, swe});
        chk({name, ".misalign"}, {31'h0, misalign}, {31'h0, mis});
    endtask

    task automatic chk_cnt(input string name);
`ifdef ARB_WRITE_COUNT_EN
        chk({name, ".cpu_wr_cnt"}, {16'h0, cpu_wr_cnt}, {16'h0, exp_cpu_cnt});
        chk({name, ".dma_wr_cnt"}, {16'h0, dma_wr_cnt}, {16'h0, exp_dma_cnt});
`else
        chk({name, ".cpu_wr_cnt"}, {16'h0, cpu_wr_cnt}, 32'h0);
        chk({name, ".dma_wr_cnt"}, {16'h0, dma_wr_cnt}, 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_pc = 32'h0;
        dma_valid = 1'b0; dma_size = 2'b00; dma_addr = 32'h0; dma_wdata = 32'h0; dma_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        req sz     addr          wdata         pc            dv sz     addr          wdata         last st rd exp_addr      exp_wdata     dwe     iwe     swe     mis chk
        vec[0]  = '{1'b1, 2'b00, 32'h1000_0002, 32'h0000_00AB, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1000_0002, 32'hABAB_ABAB, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[1]  = '{1'b1, 2'b10, 32'h2000_0000, 32'h1234_5678, 32'h0000_0040, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h2000_0000, 32'h1234_5678, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[2]  = '{1'b1, 2'b10, 32'h2000_0000, 32'h1234_5678, 32'h4000_0040, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h2000_0000, 32'h1234_5678, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1};
        vec[3]  = '{1'b1, 2'b01, 32'h1000_0001, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 2'b01, 32'h3000_0002, 32'h0000_BEEF, 32'h4000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3000_0002, 32'hBEEF_BEEF, 4'b0011, 4'b0011, 4'b0000, 1'b0, 1'b1};
        vec[5]  = '{1'b1, 2'b00, 32'hC000_0013, 32'h0000_005A, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC000_0013, 32'h5A5A_5A5A, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1};
        vec[6]  = '{1'b1, 2'b00, 32'hC000_0011, 32'h0000_005A, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hC000_0011, 32'h5A5A_5A5A, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1};
        vec[7]  = '{1'b1, 2'b01, 32'h1000_0000, 32'h0000_1234, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 32'h1234_1234, 4'b1100, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[8]  = '{1'b1, 2'b10, 32'h1000_0004, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1000_0004, 32'hCAFE_BABE, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[9]  = '{1'b1, 2'b10, 32'h1000_0002, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vec[10] = '{1'b1, 2'b11, 32'h1000_0000, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        vec[11] = '{1'b0, 2'b00, 32'h1000_0000, 32'h0000_0011, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vec[12] = '{1'b1, 2'b00, 32'h8000_0000, 32'h0000_0077, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h7777_7777, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[13] = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 2'b10, 32'h2000_0008, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1, 32'h2000_0008, 32'h0BAD_F00D, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1};
        vec[14] = '{1'b1, 2'b00, 32'h1000_0003, 32'h0000_0011, 32'h0000_0000, 1'b1, 2'b10, 32'h1000_0010, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1000_0003, 32'h1111_1111, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[15] = '{1'b1, 2'b01, 32'h1000_0002, 32'h0000_C3C3, 32'h0000_0000, 1'b1, 2'b10, 32'h1000_0010, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1000_0002, 32'hC3C3_C3C3, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vec[16] = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,          32'h0,          4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vec[17] = '{1'b0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 1'b1, 2'b01, 32'hC000_0001, 32'h0000_1111, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};

        // ---------------- reset state (store offered during reset is ignored)
        idle_inputs();
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h1000_0000; cpu_wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk_regs("reset", 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        chk_cnt("reset");
        rst_n = 1'b1;
        idle_inputs();

        // ---------------- table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            cpu_req = vec[i].cpu_req; cpu_size = vec[i].cpu_size; cpu_addr = vec[i].cpu_addr;
            cpu_wdata = vec[i].cpu_wdata; cpu_pc = vec[i].cpu_pc;
            dma_valid = vec[i].dma_valid; dma_size = vec[i].dma_size; dma_addr = vec[i].dma_addr;
            dma_wdata = vec[i].dma_wdata; dma_last = vec[i].dma_last;
            #1;
            chk($sformatf("vec%0d.cpu_stall", i), {31'h0, cpu_stall}, {31'h0, vec[i].exp_stall});
            chk($sformatf("vec%0d.dma_ready", i), {31'h0, dma_ready}, {31'h0, vec[i].exp_ready});
            tick();
            chk_regs($sformatf("vec%0d", i), vec[i].exp_addr, vec[i].exp_wdata, vec[i].exp_dwe,
                     vec[i].exp_iwe, vec[i].exp_swe, vec[i].exp_mis, vec[i].chk_data);
            if (vec[i].cpu_req && !vec[i].exp_stall && !vec[i].exp_mis) exp_cpu_cnt++;
            if (vec[i].dma_valid && vec[i].exp_ready && !vec[i].exp_mis) exp_dma_cnt++;
            chk_cnt($sformatf("vec%0d", i));
        end

        // ---------------- starvation: DMA force-granted on the 8th cycle
        idle_inputs();
        cpu_req = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h1000_0000; cpu_wdata = 32'h1111_2222;
        dma_valid = 1'b1; dma_size = 2'b10; dma_addr = 32'hC000_0010; dma_wdata = 32'hCAFE_F00D; dma_last = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("starve%0d.cpu_stall", c), {31'h0, cpu_stall}, {31'h0, (c == 8)});
            chk($sformatf("starve%0d.dma_ready", c), {31'h0, dma_ready}, {31'h0, (c == 8)});
            tick();
            if (c == 8) begin
                chk_regs("starve_dma", 32'hC000_0010, 32'hCAFE_F00D, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1);
                exp_dma_cnt++;
            end else begin
                chk_regs($sformatf("starve%0d", c), 32'h1000_0000, 32'h1111_2222, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
                exp_cpu_cnt++;
            end
        end
        chk_cnt("starve");
        // Starvation count restarts: CPU wins again right after.
        #1;
        chk("starve_after.cpu_stall", {31'h0, cpu_stall}, 32'h0);
        chk("starve_after.dma_ready", {31'h0, dma_ready}, 32'h0);
        dma_valid = 1'b0;
        tick();
        exp_cpu_cnt++;

        // ---------------- burst cap: 20-beat burst, 16 beats then back to CPU
        dma_valid = 1'b1; dma_size = 2'b10; dma_last = 1'b0;
        cpu_addr = 32'h1000_0000; cpu_wdata = 32'h3333_4444; cpu_pc = 32'h0;
        beat = 0;
        for (int k = 0; k < 31; k++) begin
            dma_addr  = 32'h3000_0000 + 32'(beat * 4);
            dma_wdata = 32'hD000_0000 + 32'(beat);
            dma_last  = (beat == 19);
            #1;
            exp_dma = ((k >= 7) && (k <= 22)) || (k == 30);
            chk($sformatf("burst%0d.dma_ready", k), {31'h0, dma_ready}, {31'h0, exp_dma});
            chk($sformatf("burst%0d.cpu_stall", k), {31'h0, cpu_stall}, {31'h0, exp_dma});
            tick();
            if (exp_dma) begin
                chk_regs($sformatf("burst%0d", k), 32'h3000_0000 + 32'(beat * 4), 32'hD000_0000 + 32'(beat),
                         4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1);
                beat++;
                exp_dma_cnt++;
            end else begin
                chk_regs($sformatf("burst%0d", k), 32'h1000_0000, 32'h3333_4444, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
                exp_cpu_cnt++;
            end
        end
        chk("burst.beats", 32'(beat), 32'd17);
        chk_cnt("burst");
        // Still in the burst: dropping dma_valid keeps the CPU stalled one cycle.
        dma_valid = 1'b0;
        #1;
        chk("burst_drop.dma_ready", {31'h0, dma_ready}, 32'h1);
        chk("burst_drop.cpu_stall", {31'h0, cpu_stall}, 32'h1);
        tick();
        chk_regs("burst_drop", 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        #1;
        chk("burst_back.dma_ready", {31'h0, dma_ready}, 32'h0);
        chk("burst_back.cpu_stall", {31'h0, cpu_stall}, 32'h0);
        tick();
        exp_cpu_cnt++;

        // ---------------- reset during burst beat 5
        cpu_req = 1'b0; dma_valid = 1'b1; dma_size = 2'b10; dma_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dma_addr = 32'h1000_0200 + 32'(k * 4); dma_wdata = 32'(k);
            #1;
            chk($sformatf("rstburst%0d.dma_ready", k), {31'h0, dma_ready}, 32'h1);
            tick();
        end
        dma_addr = 32'h1000_0214; dma_wdata = 32'h5;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cpu_cnt = 16'h0;
        exp_dma_cnt = 16'h0;
        chk_regs("rstburst", 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        chk_cnt("rstburst");
        #1;
        chk("rstburst_nocpu.dma_ready", {31'h0, dma_ready}, 32'h1);
        cpu_req = 1'b1; cpu_size = 2'b10; cpu_addr = 32'h1000_0000;
        #1;
        chk("rstburst_cpu.dma_ready", {31'h0, dma_ready}, 32'h0);
        chk("rstburst_cpu.cpu_stall", {31'h0, cpu_stall}, 32'h0);
        tick();
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
